// File: rtl/uart_rx_fsm.sv
// UART receive controller: sequences start/data/parity/stop bit windows
// for an external edge/bit counter and data sampler, assembles the byte and flags errors.
`timescale 1ns/1ps
module uart_rx_fsm (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_in,
   input  logic       sampled_bit,
   input  logic       par_en,
   input  logic       par_typ,
   input  logic [4:0] prescale,
   input  logic [4:0] edge_cnt,
   input  logic [2:0] bit_cnt,
   output logic       edge_en,
   output logic       bit_en,
   output logic       dat_samp_en,
   output logic [7:0] p_data,
   output logic       data_valid,
   output logic       par_err,
   output logic       stp_err
);

   localparam int unsigned DATA_W = 8;
   localparam int unsigned CNT_W  = 3;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      CHK    = 3'd5
   } state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] p_data_q, p_data_d;
   logic              par_en_q, par_en_d;
   logic              par_typ_q, par_typ_d;
   logic              par_err_q, par_err_d;
   logic              stp_err_q, stp_err_d;
   logic              data_valid_q, data_valid_d;
   logic              edge_en_q, edge_en_d;
   logic              bit_en_q, bit_en_d;
   logic              dat_samp_en_q, dat_samp_en_d;
   logic              bit_end;
   logic              exp_par;

   // Next state, datapath updates and Moore outputs decoded from the next state
   always_comb begin
      state_d       = state_q;
      p_data_d      = p_data_q;
      par_en_d      = par_en_q;
      par_typ_d     = par_typ_q;
      par_err_d     = par_err_q;
      stp_err_d     = stp_err_q;
      bit_end       = (edge_cnt == prescale);
      exp_par       = par_typ_q ? ~(^p_data_q) : (^p_data_q);

      unique case (state_q)
         IDLE: begin
            if (!rx_in) begin
               state_d   = START;
               par_en_d  = par_en;
               par_typ_d = par_typ;
               par_err_d = 1'b0;
               stp_err_d = 1'b0;
            end
         end
         START: begin
            // A high sample at the end of the start bit is a line glitch
            if (bit_end) begin
               state_d = sampled_bit ? IDLE : DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               p_data_d = {sampled_bit, p_data_q[DATA_W-1:1]};
               if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                  state_d = par_en_q ? PARITY : STOP;
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               par_err_d = (sampled_bit != exp_par);
               state_d   = STOP;
            end
         end
         STOP: begin
            if (bit_end) begin
               stp_err_d = ~sampled_bit;
               state_d   = CHK;
            end
         end
         CHK: begin
            // Back-to-back frame: the next start bit may already be on the line
            if (!rx_in) begin
               state_d   = START;
               par_en_d  = par_en;
               par_typ_d = par_typ;
               par_err_d = 1'b0;
               stp_err_d = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      edge_en_d     = (state_d == START) || (state_d == DATA) ||
                      (state_d == PARITY) || (state_d == STOP);
      dat_samp_en_d = edge_en_d;
      bit_en_d      = (state_d == DATA);
      data_valid_d  = (state_d == CHK) && !par_err_d && !stp_err_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         p_data_q      <= '0;
         par_en_q      <= 1'b0;
         par_typ_q     <= 1'b0;
         par_err_q     <= 1'b0;
         stp_err_q     <= 1'b0;
         data_valid_q  <= 1'b0;
         edge_en_q     <= 1'b0;
         bit_en_q      <= 1'b0;
         dat_samp_en_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         p_data_q      <= p_data_d;
         par_en_q      <= par_en_d;
         par_typ_q     <= par_typ_d;
         par_err_q     <= par_err_d;
         stp_err_q     <= stp_err_d;
         data_valid_q  <= data_valid_d;
         edge_en_q     <= edge_en_d;
         bit_en_q      <= bit_en_d;
         dat_samp_en_q <= dat_samp_en_d;
      end
   end

   assign edge_en     = edge_en_q;
   assign bit_en      = bit_en_q;
   assign dat_samp_en = dat_samp_en_q;
   assign p_data      = p_data_q;
   assign data_valid  = data_valid_q;
   assign par_err     = par_err_q;
   assign stp_err     = stp_err_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm with a behavioural edge/bit counter and
// centre-of-bit sampler, prescale = 7 (8 clocks per bit).
`timescale 1ns/1ps
module tb_uart_rx_fsm;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_in;
   logic       sampled_bit;
   logic       par_en;
   logic       par_typ;
   logic [4:0] prescale;
   logic [4:0] edge_cnt;
   logic [2:0] bit_cnt;
   logic       edge_en;
   logic       bit_en;
   logic       dat_samp_en;
   logic [7:0] p_data;
   logic       data_valid;
   logic       par_err;
   logic       stp_err;

   int         n_chk   = 0;
   int         n_bad   = 0;
   int         cyc     = 0;
   int         dv_cnt  = 0;
   int         dv_cyc  = 0;
   logic [7:0] dv_data = 8'h00;
   int         t_start = 0;
   int         dv_before;

   uart_rx_fsm dut (
      .clk         (clk),
      .rst         (rst),
      .rx_in       (rx_in),
      .sampled_bit (sampled_bit),
      .par_en      (par_en),
      .par_typ     (par_typ),
      .prescale    (prescale),
      .edge_cnt    (edge_cnt),
      .bit_cnt     (bit_cnt),
      .edge_en     (edge_en),
      .bit_en      (bit_en),
      .dat_samp_en (dat_samp_en),
      .p_data      (p_data),
      .data_valid  (data_valid),
      .par_err     (par_err),
      .stp_err     (stp_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Edge/bit counter model
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         edge_cnt <= '0;
         bit_cnt  <= '0;
      end else begin
         if (edge_en) edge_cnt <= (edge_cnt == prescale) ? 5'd0 : edge_cnt + 5'd1;
         else         edge_cnt <= '0;
         if (!bit_en)                     bit_cnt <= '0;
         else if (edge_cnt == prescale)   bit_cnt <= bit_cnt + 3'd1;
      end
   end

   // Sampler: captures the line at the middle of each bit window
   always @(posedge clk or negedge rst) begin
      if (!rst)                                          sampled_bit <= 1'b1;
      else if (dat_samp_en && edge_cnt == (prescale >> 1)) sampled_bit <= rx_in;
   end

   always @(negedge clk) begin
      if (data_valid === 1'b1) begin
         dv_cnt++;
         dv_cyc  = cyc;
         dv_data = p_data;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   task automatic drive_bit(input logic b);
      rx_in = b;
      repeat (8) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                             input logic pbit, input logic sbit,
                             input int n_bits, input bit chk_start);
      par_en  = pe;
      par_typ = pt;
      rx_in   = 1'b0;
      @(posedge clk);
      #1;
      t_start = cyc;
      if (chk_start) begin
         check("start_edge_en", 32'(edge_en), 32'd1);
         check("start_samp_en", 32'(dat_samp_en), 32'd1);
         check("start_bit_en", 32'(bit_en), 32'd0);
         check("start_stp_err", 32'(stp_err), 32'd0);
         check("start_par_err", 32'(par_err), 32'd0);
      end
      repeat (7) @(posedge clk);
      #1;
      // Config flips mid-frame must not disturb this frame
      par_en  = ~pe;
      par_typ = ~pt;
      for (int i = 0; i < n_bits; i++) drive_bit(d[i]);
      if (n_bits == 8) begin
         if (pe) drive_bit(pbit);
         drive_bit(sbit);
      end
      rx_in = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst      = 1'b0;
      rx_in    = 1'b1;
      par_en   = 1'b0;
      par_typ  = 1'b0;
      prescale = 5'd7;
      #3;
      check("rst_p_data", 32'(p_data), 32'h00);
      check("rst_dv", 32'(data_valid), 32'd0);
      check("rst_par_err", 32'(par_err), 32'd0);
      check("rst_stp_err", 32'(stp_err), 32'd0);
      check("rst_edge_en", 32'(edge_en), 32'd0);
      check("rst_bit_en", 32'(bit_en), 32'd0);
      check("rst_samp_en", 32'(dat_samp_en), 32'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // 0xA5, even parity (bit 0), stop 1
      dv_before = dv_cnt;
      send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 8, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      check("a5_dv_count", 32'(dv_cnt - dv_before), 32'd1);
      check("a5_latency", 32'(dv_cyc - t_start), 32'd88);
      check("a5_data", 32'(dv_data), 32'hA5);
      check("a5_par_err", 32'(par_err), 32'd0);
      check("a5_stp_err", 32'(stp_err), 32'd0);

      // 0x3C, no parity
      dv_before = dv_cnt;
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 8, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      check("3c_dv_count", 32'(dv_cnt - dv_before), 32'd1);
      check("3c_latency", 32'(dv_cyc - t_start), 32'd80);
      check("3c_data", 32'(dv_data), 32'h3C);

      // 0x01, odd parity expects 0; send 1
      dv_before = dv_cnt;
      send_frame(8'h01, 1'b1, 1'b1, 1'b1, 1'b1, 8, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      check("perr_dv_count", 32'(dv_cnt - dv_before), 32'd0);
      check("perr_par_err", 32'(par_err), 32'd1);
      check("perr_stp_err", 32'(stp_err), 32'd0);
      check("perr_idle", 32'(edge_en), 32'd0);

      // Stop bit low
      dv_before = dv_cnt;
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      check("serr_dv_count", 32'(dv_cnt - dv_before), 32'd0);
      check("serr_stp_err", 32'(stp_err), 32'd1);
      check("serr_par_err", 32'(par_err), 32'd0);

      // Following valid frame clears stp_err at START entry
      dv_before = dv_cnt;
      send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 8, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      check("c3_dv_count", 32'(dv_cnt - dv_before), 32'd1);
      check("c3_data", 32'(dv_data), 32'hC3);
      check("c3_stp_err", 32'(stp_err), 32'd0);

      // Start glitch: low for 3 clocks only
      dv_before = dv_cnt;
      rx_in = 1'b0;
      repeat (3) @(posedge clk);
      #1 rx_in = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      check("gl_dv_count", 32'(dv_cnt - dv_before), 32'd0);
      check("gl_idle", 32'(edge_en), 32'd0);
      check("gl_par_err", 32'(par_err), 32'd0);
      check("gl_stp_err", 32'(stp_err), 32'd0);
      check("gl_p_data", 32'(p_data), 32'hC3);

      // Back-to-back 0x55 then 0xAA, reset during the second data byte
      dv_before = dv_cnt;
      send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 8, 1'b1);
      send_frame(8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 4, 1'b0);
      check("b2b_dv_count", 32'(dv_cnt - dv_before), 32'd1);
      check("b2b_data", 32'(dv_data), 32'h55);
      check("b2b_mid_edge_en", 32'(edge_en), 32'd1);
      rst = 1'b0;
      #1;
      check("mrst_p_data", 32'(p_data), 32'h00);
      check("mrst_dv", 32'(data_valid), 32'd0);
      check("mrst_edge_en", 32'(edge_en), 32'd0);
      check("mrst_bit_en", 32'(bit_en), 32'd0);
      check("mrst_samp_en", 32'(dat_samp_en), 32'd0);
      check("mrst_errs", 32'({par_err, stp_err}), 32'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("post_rst_p_data", 32'(p_data), 32'h00);

      // 0x0F, even parity (bit 0)
      dv_before = dv_cnt;
      send_frame(8'h0F, 1'b1, 1'b0, 1'b0, 1'b1, 8, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      check("0f_dv_count", 32'(dv_cnt - dv_before), 32'd1);
      check("0f_latency", 32'(dv_cyc - t_start), 32'd88);
      check("0f_data", 32'(dv_data), 32'h0F);
      check("0f_errs", 32'({par_err, stp_err}), 32'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
